router_fsm_n: RTL and testbench

Parametrised packet-router control FSM for an N-output router. It sits between the input register/parity block and the N output FIFOs. It decodes the header address and sequences header, payload and parity loads. It also handles FIFO-full back-pressure, destination-busy waiting and soft-reset aborts. Compared with the fixed 3-port controller it adds:
- a latched one-hot destination
- invalid-address packet dropping
- per-destination soft-reset qualification
- an optional wait-till-empty timeout

---
 rtl/router_fsm_n.sv | 185 ++++++++++++++++++
 tb/tb_router_fsm_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_n.sv
// rtl/router_fsm_n.sv - N-output packet router control FSM; ROUTER_FSM_TIMEOUT_EN enables the wait-till-empty timeout
module router_fsm_n #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 lfd_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 addr_err,
    output logic                 wait_timeout
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] dest_sel_q, dest_sel_d;
    logic [NUM_PORTS-1:0] addr_onehot;
    logic [31:0]          addr_ext;
    logic                 addr_bad;
    logic                 dest_empty;
    logic                 soft_hit;
    logic                 timeout_hit;

    logic write_enb_reg_q, write_enb_reg_d;
    logic detect_add_q, detect_add_d;
    logic ld_state_q, ld_state_d;
    logic laf_state_q, laf_state_d;
    logic lfd_state_q, lfd_state_d;
    logic full_state_q, full_state_d;
    logic rst_int_reg_q, rst_int_reg_d;
    logic busy_q, busy_d;
    logic addr_err_q, addr_err_d;

    assign addr_ext    = 32'(data_in);
    assign addr_bad    = (addr_ext >= 32'(NUM_PORTS));
    assign addr_onehot = NUM_PORTS'(1) << data_in;
    // The wait and soft-reset qualification use the latched destination, never live data_in.
    assign dest_empty  = |(empty & dest_sel_q);
    assign soft_hit    = (|(soft_reset & dest_sel_q)) &&
                         (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET);

`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign timeout_hit = (state_q == WAIT_TILL_EMPTY) && !dest_empty &&
                         (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
    assign wait_cnt_d  = ((state_q == WAIT_TILL_EMPTY) && (state_d == WAIT_TILL_EMPTY)) ?
                         wait_cnt_q + CNT_W'(1) : '0;
`else
    logic unused_wait_timeout_cfg;
    assign unused_wait_timeout_cfg = (WAIT_TIMEOUT > 0);
    assign timeout_hit = 1'b0;
`endif

    assign wait_timeout = timeout_hit && !soft_hit;

    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (addr_bad) begin
                        state_d = DROP_PACKET;
                    end else begin
                        dest_sel_d = addr_onehot;
                        state_d    = (|(empty & addr_onehot)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_d = DECODE_ADDRESS;
                else if (low_packet_valid) state_d = LOAD_PARITY;
                else                       state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (dest_empty)       state_d = LOAD_FIRST_DATA;
                else if (timeout_hit) state_d = DROP_PACKET;
            end
            DROP_PACKET: begin
                if (!pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        if (soft_hit) state_d = DECODE_ADDRESS;
        if (state_d == DECODE_ADDRESS) dest_sel_d = '0;

        // Outputs are registered decodes of the next state, so they track the present state.
        write_enb_reg_d = (state_d == LOAD_DATA) || (state_d == LOAD_AFTER_FULL) ||
                          (state_d == LOAD_PARITY);
        detect_add_d    = (state_d == DECODE_ADDRESS);
        ld_state_d      = (state_d == LOAD_DATA);
        laf_state_d     = (state_d == LOAD_AFTER_FULL);
        lfd_state_d     = (state_d == LOAD_FIRST_DATA);
        full_state_d    = (state_d == FIFO_FULL_STATE);
        rst_int_reg_d   = (state_d == CHECK_PARITY_ERROR);
        busy_d          = !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA) ||
                            (state_d == DROP_PACKET));
        addr_err_d      = (state_d == DROP_PACKET) && (state_q == DECODE_ADDRESS || addr_err_q);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q         <= DECODE_ADDRESS;
            dest_sel_q      <= '0;
            write_enb_reg_q <= 1'b0;
            detect_add_q    <= 1'b1;
            ld_state_q      <= 1'b0;
            laf_state_q     <= 1'b0;
            lfd_state_q     <= 1'b0;
            full_state_q    <= 1'b0;
            rst_int_reg_q   <= 1'b0;
            busy_q          <= 1'b0;
            addr_err_q      <= 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
            wait_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            dest_sel_q      <= dest_sel_d;
            write_enb_reg_q <= write_enb_reg_d;
            detect_add_q    <= detect_add_d;
            ld_state_q      <= ld_state_d;
            laf_state_q     <= laf_state_d;
            lfd_state_q     <= lfd_state_d;
            full_state_q    <= full_state_d;
            rst_int_reg_q   <= rst_int_reg_d;
            busy_q          <= busy_d;
            addr_err_q      <= addr_err_d;
`ifdef ROUTER_FSM_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
`endif
        end
    end

    assign write_enb_reg = write_enb_reg_q;
    assign detect_add    = detect_add_q;
    assign ld_state      = ld_state_q;
    assign laf_state     = laf_state_q;
    assign lfd_state     = lfd_state_q;
    assign full_state    = full_state_q;
    assign rst_int_reg   = rst_int_reg_q;
    assign busy          = busy_q;
    assign addr_err      = addr_err_q;
    assign dest_sel      = dest_sel_q;

endmodule

// File: tb/tb_router_fsm_n.sv
// tb/tb_router_fsm_n.sv - randomized bench for router_fsm_n against a behavioural packet-flow model
module tb_router_fsm_n;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int WT = 8;
`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int S_DEC = 0, S_LFD = 1, S_LD = 2, S_FULL = 3, S_LAF = 4;
    localparam int S_LP = 5, S_CPE = 6, S_WAIT = 7, S_DROP = 8;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [AW-1:0] data_in;
    logic          fifo_full;
    logic [NP-1:0] empty;
    logic [NP-1:0] soft_reset;
    logic          parity_done;
    logic          low_packet_valid;
    logic          write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
    logic          full_state, rst_int_reg, busy, addr_err, wait_timeout;
    logic [NP-1:0] dest_sel;

    int            checks = 0;
    int            errors = 0;

    int            m_st;
    int            m_wait_cycles;
    int            m_dest_port;
    bit            m_bad_drop;
    bit            m_valid = 1'b0;

    router_fsm_n #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .empty(empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .dest_sel(dest_sel),
        .addr_err(addr_err), .wait_timeout(wait_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] dest_mask();
        return (m_dest_port < 0) ? '0 : NP'(1) << m_dest_port;
    endfunction

    function automatic bit dest_is_empty();
        return (m_dest_port >= 0) && empty[m_dest_port];
    endfunction

    function automatic bit dest_soft_reset();
        return (m_dest_port >= 0) && soft_reset[m_dest_port] &&
               (m_st != S_DEC) && (m_st != S_DROP);
    endfunction

    function automatic bit expect_timeout();
        return TMO_EN && (m_st == S_WAIT) && !dest_is_empty() &&
               (m_wait_cycles == WT - 1) && !dest_soft_reset();
    endfunction

    task automatic compare_all();
        if (!m_valid) return;
        check("detect_add",   detect_add,    m_st == S_DEC);
        check("lfd_state",    lfd_state,     m_st == S_LFD);
        check("ld_state",     ld_state,      m_st == S_LD);
        check("full_state",   full_state,    m_st == S_FULL);
        check("laf_state",    laf_state,     m_st == S_LAF);
        check("rst_int_reg",  rst_int_reg,   m_st == S_CPE);
        check("write_enb",    write_enb_reg, m_st inside {S_LD, S_LAF, S_LP});
        check("busy",         busy,          !(m_st inside {S_DEC, S_LD, S_DROP}));
        check("addr_err",     addr_err,      (m_st == S_DROP) && m_bad_drop);
        check("dest_sel",     dest_sel,      dest_mask());
        check("wait_timeout", wait_timeout,  expect_timeout());
    endtask

    task automatic model_update();
        int  nx;
        bit  tmo;
        if (!resetn) begin
            m_st = S_DEC; m_dest_port = -1; m_wait_cycles = 0; m_bad_drop = 0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        tmo = expect_timeout();
        nx  = m_st;
        case (m_st)
            S_DEC: if (pkt_valid) begin
                if (int'(data_in) >= NP) begin
                    nx = S_DROP; m_bad_drop = 1;
                end else begin
                    m_dest_port = int'(data_in);
                    nx = empty[m_dest_port] ? S_LFD : S_WAIT;
                end
            end
            S_LFD:  nx = S_LD;
            S_LD:   nx = fifo_full ? S_FULL : (!pkt_valid ? S_LP : S_LD);
            S_FULL: nx = fifo_full ? S_FULL : S_LAF;
            S_LAF:  nx = parity_done ? S_DEC : (low_packet_valid ? S_LP : S_LD);
            S_LP:   nx = S_CPE;
            S_CPE:  nx = fifo_full ? S_FULL : S_DEC;
            S_WAIT: begin
                if (dest_is_empty()) nx = S_LFD;
                else if (tmo) begin nx = S_DROP; m_bad_drop = 0; end
            end
            default: nx = pkt_valid ? S_DROP : S_DEC;
        endcase
        if (dest_soft_reset()) nx = S_DEC;
        m_wait_cycles = (m_st == S_WAIT && nx == S_WAIT) ? m_wait_cycles + 1 : 0;
        if (nx == S_DEC) m_dest_port = -1;
        m_st = nx;
    endtask

    task automatic drive(input logic pv, input logic [AW-1:0] din, input logic ff,
                         input logic [NP-1:0] emp, input logic [NP-1:0] sr,
                         input logic pd, input logic lpv, input logic rn);
        pkt_valid = pv; data_in = din; fifo_full = ff; empty = emp; soft_reset = sr;
        parity_done = pd; low_packet_valid = lpv; resetn = rn;
        #1 compare_all();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    function automatic logic [NP-1:0] rand_bits(input int one_in);
        logic [NP-1:0] v;
        for (int b = 0; b < NP; b++) v[b] = ($urandom_range(0, one_in - 1) == 0);
        return v;
    endfunction

    initial begin
        @(negedge clock);
        repeat (2) drive(0, 0, 0, '1, 0, 0, 0, 0);

        // Minimum-latency packet to port 2 with four payload bytes.
        drive(1, 2, 0, 3'b111, 0, 0, 0, 1);
        repeat (4) drive(1, 0, 0, 3'b111, 0, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 3'b111, 0, 0, 0, 1);

        // Out-of-range header is dropped until pkt_valid falls.
        repeat (3) drive(1, 3, 0, 3'b111, 0, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 3'b111, 0, 0, 0, 1);

        // Back-pressure mid-payload.
        drive(1, 0, 0, 3'b111, 0, 0, 0, 1);
        repeat (2) drive(1, 0, 0, 3'b111, 0, 0, 0, 1);
        repeat (3) drive(1, 0, 1, 3'b111, 0, 0, 0, 1);
        repeat (3) drive(1, 0, 0, 3'b111, 0, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 3'b111, 0, 0, 0, 1);

        // Soft reset of a non-selected port is ignored; the selected port aborts.
        drive(1, 1, 0, 3'b101, 0, 0, 0, 1);
        repeat (3) drive(1, 0, 0, 3'b101, 3'b001, 0, 0, 1);
        drive(1, 0, 0, 3'b101, 3'b010, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 3'b101, 0, 0, 0, 1);

        // Timeout while waiting for port 0, then empty rising on the last wait cycle.
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1);
        repeat (10) drive(0, 0, 0, 3'b000, 0, 0, 0, 1);
        drive(1, 0, 0, 3'b000, 0, 0, 0, 1);
        repeat (WT - 1) drive(1, 0, 0, 3'b000, 0, 0, 0, 1);
        drive(1, 0, 0, 3'b001, 0, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 3'b001, 0, 0, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0, rand_bits(3), rand_bits(40),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 199) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
